// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction-fetch
//                controller (state encoding, FIFO entry layout, defaults).
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Size of one instruction word in bytes; the fetch PC advances by this.
    localparam int unsigned c_INSTR_BYTES = 4;

    // Default widths for the package-level FIFO entry type.
    localparam int unsigned c_DEFAULT_AW = 32;
    localparam int unsigned c_DEFAULT_DW = 32;

    // Default first fetch address after reset.
    localparam logic [31:0] c_DEFAULT_RESET_PC = 32'h0000_0000;

    // Fetch controller states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DISCARD = 2'd2,
        ST_HALT    = 2'd3
    } fetch_state_t;

    // One buffered instruction together with the address it came from.
    typedef struct packed {
        logic [c_DEFAULT_DW-1:0] instr;
        logic [c_DEFAULT_AW-1:0] pc;
    } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Small synchronous FIFO for fetched instructions. Flush
//                wins over push and pop; push when full and pop when empty
//                are ignored. Head entry is presented combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter type         ENTRY_T = fifo_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  ENTRY_T                 wr_data,
    output ENTRY_T                 rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_FULL_CNT = (c_PTR_W + 1)'(DEPTH);

    ENTRY_T             r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == c_FULL_CNT);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rd_data   = r_mem[r_rd_ptr];
    assign w_do_push = push && !full && !flush;
    assign w_do_pop  = pop && !empty && !flush;

    // Storage write: only on an accepted push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
    // pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Instruction-fetch controller. Owns the fetch PC, issues
//                word requests to instruction memory, buffers returned
//                words with their PCs toward decode, and handles redirects
//                and slow memory acknowledgement.
//                Optional macro FETCH_ALIGN_CHECK_EN adds a 'misaligned'
//                output and a HALT state entered on unaligned redirects.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(c_DEFAULT_RESET_PC),
    parameter int unsigned              FIFO_DEPTH    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     mem_req,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic                     mem_ack,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic                     misaligned,
`endif
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc
);

    localparam int unsigned             c_CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_CNT_W-1:0]      c_DEPTH_CNT = c_CNT_W'(FIFO_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] c_PC_STEP  = ADDRESS_WIDTH'(c_INSTR_BYTES);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    instr;
        logic [ADDRESS_WIDTH-1:0] pc;
    } entry_t;

    fetch_state_t               r_state;
    logic [ADDRESS_WIDTH-1:0]   r_fetch_pc;
    logic [ADDRESS_WIDTH-1:0]   r_pend_addr;
    logic [DATA_WIDTH-1:0]      r_last_instr;
    logic [ADDRESS_WIDTH-1:0]   r_last_pc;

    logic                       w_mem_req;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_empty;
    logic                       w_full_unused;
    logic [c_CNT_W-1:0]         w_count;
    logic [ADDRESS_WIDTH-1:0]   w_redirect_target;
    logic [ADDRESS_WIDTH-1:0]   w_pc_next;
    entry_t                     w_wr_entry;
    entry_t                     w_head;

    // Redirect targets are forced onto a word boundary.
    assign w_redirect_target = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
    assign w_pc_next         = r_fetch_pc + c_PC_STEP;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_misaligned;
    assign misaligned = r_misaligned;
`else
    logic w_unused_low_bits;
    assign w_unused_low_bits = ^redirect_pc[1:0];
`endif

    // Request generation uses only the registered occupancy, so decode's
    // ready never reaches mem_req combinationally.
    always_comb begin
        w_mem_req = 1'b0;
        case (r_state)
            ST_FETCH:   w_mem_req = (w_count < c_DEPTH_CNT);
            ST_DISCARD: w_mem_req = 1'b1;
            default:    w_mem_req = 1'b0;
        endcase
    end

    // While discarding, the stale request address stays on the bus even
    // though the fetch PC already holds the redirect target.
    assign mem_req  = w_mem_req;
    assign mem_addr = (r_state == ST_DISCARD) ? r_pend_addr : r_fetch_pc;

    // A redirect drops both the same-cycle ack data and the same-cycle pop.
    assign w_push = (r_state == ST_FETCH) && w_mem_req && mem_ack && !redirect;
    assign w_pop  = instr_valid && instr_ready && !redirect;

    // Assemble the entry written on a successful handshake.
    always_comb begin
        w_wr_entry       = '0;
        w_wr_entry.instr = mem_rdata;
        w_wr_entry.pc    = r_fetch_pc;
    end

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .ENTRY_T (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (w_push),
        .pop     (w_pop),
        .flush   (redirect),
        .wr_data (w_wr_entry),
        .rd_data (w_head),
        .count   (w_count),
        .full    (w_full_unused),
        .empty   (w_empty)
    );

    // State, fetch PC and stale-request address; redirect overrides all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_fetch_pc  <= RESET_PC;
            r_pend_addr <= RESET_PC;
        end else if (redirect) begin
            r_fetch_pc <= w_redirect_target;
`ifdef FETCH_ALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) begin
                r_state <= ST_HALT;
            end else
`endif
            if (w_mem_req && !mem_ack) begin
                r_state     <= ST_DISCARD;
                r_pend_addr <= mem_addr;
            end else begin
                r_state <= ST_FETCH;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (w_push) begin
                        r_fetch_pc <= w_pc_next;
                    end
                end
                ST_DISCARD: begin
                    if (mem_ack) begin
                        r_state <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Sticky misalignment flag, cleared only by an aligned redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misaligned <= 1'b0;
        end else if (redirect) begin
            r_misaligned <= (redirect_pc[1:0] != 2'b00);
        end
    end
`endif

    // Remember the last presented head so outputs hold while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_instr <= '0;
            r_last_pc    <= '0;
        end else if (!w_empty) begin
            r_last_instr <= w_head.instr;
            r_last_pc    <= w_head.pc;
        end
    end

    assign instr_valid = !w_empty;
    assign instr       = w_empty ? r_last_instr : w_head.instr;
    assign instr_pc    = w_empty ? r_last_pc    : w_head.pc;

endmodule
`default_nettype wire
